floo_rr_link_arbiter: RTL and testbench

//  Wormhole-aware round-robin arbiter that shares one NoC mesh link direction between NumIn

---
 rtl/floo_rr_link_arbiter.sv | 92 +++++++++
 tb/tb_floo_rr_link_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/floo_rr_link_arbiter.sv
// floo_rr_link_arbiter: wormhole-aware round-robin arbiter feeding one registered NoC link
module floo_rr_link_arbiter #(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 64,
  parameter bit          LockEn    = 1'b1,
  localparam int unsigned IW       = NumIn > 1 ? $clog2(NumIn) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumIn-1:0]           valid_i,
  output logic [NumIn-1:0]           ready_o,
  input  logic [NumIn*DataWidth-1:0] data_i,
  input  logic [NumIn-1:0]           last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth-1:0]       data_o,
  output logic                       last_o,
  output logic [IW-1:0]              gnt_idx_o,
  output logic                       locked_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, lock_q, win;
  logic          found, can_load, xfer, last_eff;
  logic [11:0]   lock_cnt;

  assign can_load = !valid_o || ready_i;
  assign xfer     = found && can_load && !rst_i;
  assign last_eff = !LockEn || last_i[win];
  assign ready_o  = xfer ? NumIn'(1) << win : '0;

  // Winner: the held source while locked, else first valid source from the RR pointer upward
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (state_q == LOCKED) begin
      win   = lock_q;
      found = valid_i[lock_q];
    end else begin
      for (int i = 0; i < NumIn; i++)
        if (!found && valid_i[(int'(rr_q) + i) % NumIn]) begin
          found = 1'b1;
          win   = IW'((int'(rr_q) + i) % NumIn);
        end
    end
  end

  // Lock state register
  always_ff @(posedge clk_i)
    state_q <= rst_i ? IDLE : state_d;

  // Lock next state: a non-last transfer opens or keeps a packet, a last transfer closes it
  always_comb
    state_d = xfer ? (last_eff ? IDLE : LOCKED) : state_q;

  // Lock outputs
  always_comb
    locked_o = state_q == LOCKED;

  // Output pipeline register, lock index and RR pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      data_o    <= '0;
      last_o    <= 1'b0;
      gnt_idx_o <= '0;
      rr_q      <= '0;
      lock_q    <= '0;
    end else begin
      if (can_load) valid_o <= xfer;
      if (xfer) begin
        data_o    <= data_i[win*DataWidth +: DataWidth];
        last_o    <= last_i[win];
        gnt_idx_o <= win;
        if (state_q == IDLE) lock_q <= win;
        if (last_eff) rr_q <= IW'((int'(win) + 1) % NumIn);
      end
    end
  end

  // Cycles spent holding a grant, saturating; watches for packets that never end
  always_ff @(posedge clk_i)
    lock_cnt <= (rst_i || !locked_o) ? '0 : (lock_cnt == '1 ? lock_cnt : lock_cnt + 12'd1);

  a_onehot_ready: assert property (@(posedge clk_i) $onehot0(ready_o));
  a_stable_out: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o && !ready_i |=> valid_o && $stable(data_o) && $stable(last_o) && $stable(gnt_idx_o));
  a_lock_ends: assert property (@(posedge clk_i) disable iff (rst_i) lock_cnt != '1);

endmodule

// File: tb/tb_floo_rr_link_arbiter.sv
// tb_floo_rr_link_arbiter: directed and random checks of the link arbiter against a packet-level model
module tb_floo_rr_link_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk_i = 1'b0, rst_i = 1'b1, ready_i = 1'b1;
  logic [N-1:0]  valid_i = '0, last_i = '0;
  logic [N*DW-1:0] data_i = '0;
  logic [N-1:0]  r0, r1;
  logic          v0, v1, l0, l1, k0, k1;
  logic [DW-1:0] d0, d1;
  logic [1:0]    g0, g1;

  floo_rr_link_arbiter #(.NumIn(N), .DataWidth(DW), .LockEn(1'b1)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r0), .data_i(data_i),
    .last_i(last_i), .valid_o(v0), .ready_i(ready_i), .data_o(d0), .last_o(l0),
    .gnt_idx_o(g0), .locked_o(k0));

  floo_rr_link_arbiter #(.NumIn(N), .DataWidth(DW), .LockEn(1'b0)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(r1), .data_i(data_i),
    .last_i(last_i), .valid_o(v1), .ready_i(ready_i), .data_o(d1), .last_o(l1),
    .gnt_idx_o(g1), .locked_o(k1));

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model per instance (0: lock enabled, 1: lock disabled): packet owner, RR pointer, output slot
  int            owner[2] = '{-1, -1};
  int            ptr[2]   = '{0, 0};
  int            og[2]    = '{0, 0};
  logic          ov[2]    = '{1'b0, 1'b0};
  logic          ol[2]    = '{1'b0, 1'b0};
  logic [DW-1:0] od[2]    = '{'0, '0};

  logic [DW:0]   q[N][$];
  logic [N-1:0]  en = '1;
  logic [N-1:0]  pre_r[2];
  int            sel = 0;

  function automatic int pick(input int m);
    if (owner[m] >= 0) return valid_i[owner[m]] ? owner[m] : -1;
    for (int i = 0; i < N; i++)
      if (valid_i[(ptr[m] + i) % N]) return (ptr[m] + i) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      valid_i[k] = en[k] && q[k].size() > 0;
      last_i[k]  = q[k].size() > 0 ? q[k][0][DW] : 1'b0;
      data_i[k*DW +: DW] = q[k].size() > 0 ? q[k][0][DW-1:0] : '0;
    end
  endtask

  task automatic step();
    int           w[2];
    logic [N-1:0] er[2];
    logic         lf;
    #1;
    for (int m = 0; m < 2; m++) begin
      w[m]  = pick(m);
      er[m] = (!rst_i && w[m] >= 0 && (!ov[m] || ready_i)) ? N'(1) << w[m] : '0;
    end
    pre_r[0] = r0;
    pre_r[1] = r1;
    chk("ready_lk", r0, er[0]);
    chk("ready_nl", r1, er[1]);
    @(posedge clk_i);
    for (int m = 0; m < 2; m++) begin
      if (rst_i) begin
        ov[m] = 0; od[m] = '0; ol[m] = 0; og[m] = 0; owner[m] = -1; ptr[m] = 0;
      end else if (!ov[m] || ready_i) begin
        ov[m] = w[m] >= 0;
        if (w[m] >= 0) begin
          od[m]    = data_i[w[m]*DW +: DW];
          ol[m]    = last_i[w[m]];
          og[m]    = w[m];
          lf       = (m == 1) || last_i[w[m]];
          owner[m] = lf ? -1 : w[m];
          if (lf) ptr[m] = (w[m] + 1) % N;
        end
      end
    end
    for (int k = 0; k < N; k++)
      if (er[sel][k] && q[k].size() > 0) void'(q[k].pop_front());
    #1;
    chk("valid_lk", v0, ov[0]);  chk("data_lk", d0, od[0]);  chk("last_lk", l0, ol[0]);
    chk("gnt_lk", g0, og[0]);    chk("locked_lk", k0, owner[0] >= 0);
    chk("valid_nl", v1, ov[1]);  chk("data_nl", d1, od[1]);  chk("last_nl", l1, ol[1]);
    chk("gnt_nl", g1, og[1]);    chk("locked_nl", k1, owner[1] >= 0);
  endtask

  task automatic run(input int n);
    repeat (n) begin drive(); step(); end
  endtask

  task automatic reset_all();
    rst_i = 1'b1;
    en    = '1;
    for (int k = 0; k < N; k++) q[k].delete();
    drive();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    int eg[5] = '{2, 2, 2, 0, 1};
    int ek[5] = '{1, 1, 0, 0, 0};
    // Reset with every source requesting, then single-flit round robin
    rst_i = 1'b1; valid_i = '1; ready_i = 1'b1;
    step(); step();
    chk("rst_valid", v0, 0); chk("rst_ready", pre_r[0], 0); chk("rst_locked", k0, 0);
    rst_i = 1'b0;
    for (int k = 0; k < N; k++) repeat (2) q[k].push_back({1'b1, DW'(16'h1000 + k)});
    for (int i = 0; i < 5; i++) begin
      drive(); step();
      chk("t1_gnt", g0, i % 4); chk("t1_valid", v0, 1);
    end
    run(6);
    // Three-flit packet from source 2 holds the link while 0 and 1 wait
    reset_all();
    q[1].push_back({1'b1, 16'h0011});
    run(1);
    q[2].push_back({1'b0, 16'h0201}); q[2].push_back({1'b0, 16'h0202}); q[2].push_back({1'b1, 16'h0203});
    q[0].push_back({1'b1, 16'h0001}); q[1].push_back({1'b1, 16'h0012});
    for (int i = 0; i < 5; i++) begin
      drive(); step();
      chk("t2_gnt", g0, eg[i]); chk("t2_locked", k0, ek[i]);
      if (i < 3) chk("t2_data", d0, 16'h0201 + i);
    end
    run(3);
    // Backpressure holds 0xA5, then it leaves once and the next flit follows
    reset_all();
    q[0].push_back({1'b1, 16'h00A5}); q[0].push_back({1'b1, 16'h005A});
    drive(); step();
    chk("t3_load", d0, 16'h00A5);
    ready_i = 1'b0;
    repeat (5) begin
      drive(); step();
      chk("t3_hold", d0, 16'h00A5); chk("t3_noready", pre_r[0], 0); chk("t3_valid", v0, 1);
    end
    ready_i = 1'b1;
    drive(); step();
    chk("t3_next", d0, 16'h005A); chk("t3_valid2", v0, 1);
    run(2);
    // Locked source 1 stalls; source 0 must not be granted
    reset_all();
    q[1].push_back({1'b0, 16'h0011}); q[1].push_back({1'b0, 16'h0012}); q[1].push_back({1'b1, 16'h0013});
    q[0].push_back({1'b1, 16'h0001});
    en = 4'b0010;
    drive(); step();
    chk("t4_locked", k0, 1); chk("t4_first", d0, 16'h0011);
    en = 4'b0001;
    repeat (3) begin
      drive(); step();
      chk("t4_no_r0", pre_r[0][0], 0); chk("t4_held", k0, 1);
    end
    en = '1;
    for (int i = 0; i < 2; i++) begin
      drive(); step();
      chk("t4_resume", d0, 16'h0012 + i);
    end
    drive(); step();
    chk("t4_src0", d0, 16'h0001);
    run(2);
    // Reset in the middle of a packet clears lock, output and pointer
    reset_all();
    q[2].push_back({1'b0, 16'h0021}); q[2].push_back({1'b1, 16'h0022});
    drive(); step();
    chk("t5_locked", k0, 1);
    rst_i = 1'b1;
    drive(); step();
    chk("t5_unlock", k0, 0); chk("t5_empty", v0, 0);
    rst_i = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    q[3].push_back({1'b1, 16'h0033});
    drive(); step();
    chk("t5_src3", g0, 3); chk("t5_data", d0, 16'h0033);
    q[1].push_back({1'b1, 16'h0041}); q[2].push_back({1'b1, 16'h0042});
    drive(); step();
    chk("t5_wrap", g0, 1);
    run(2);
    // Lock disabled: two-flit packets interleave
    sel = 1;
    reset_all();
    q[0].push_back({1'b0, 16'h00A0}); q[0].push_back({1'b1, 16'h00A1});
    q[1].push_back({1'b0, 16'h00B0}); q[1].push_back({1'b1, 16'h00B1});
    for (int i = 0; i < 4; i++) begin
      drive(); step();
      chk("t6_gnt", g1, i % 2); chk("t6_locked", k1, 0);
    end
    run(2);
    sel = 0;
    // Random traffic, backpressure and occasional reset against the model
    for (int k = 0; k < N; k++) q[k].delete();
    for (int c = 0; c < 2000; c++) begin
      rst_i   = $urandom_range(0, 127) == 0;
      valid_i = N'($urandom);
      last_i  = N'($urandom);
      data_i  = {$urandom, $urandom};
      ready_i = $urandom_range(0, 3) != 0;
      step();
    end
    rst_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
